// File: rtl/sp_ram_arbiter_if.sv
// Request/grant/response bundle between one bus master and the RAM arbiter.
// The master drives the request and payload; the arbiter returns grant,
// response valid and read data.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic                    rvalid;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin front end for the single-port RAM wrapper.
// m0 = instruction fetch, m1 = data LSU. Grants are combinational, the RAM
// returns read data one cycle after the access, and each master keeps its
// last read word visible until its next read response.
//
// prio state | meaning
// PRIO_M0    | m0 wins when both request (reset value)
// PRIO_M1    | m1 wins when both request
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  sp_ram_arbiter_if.slave         m0,
  sp_ram_arbiter_if.slave         m1,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    PRIO_M0 = 1'b0,
    PRIO_M1 = 1'b1
  } prio_e;

  prio_e                 prio_q, prio_d;
  logic [1:0]            rv_q, rv_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
  logic [DATA_WIDTH-1:0] hold1_q, hold1_d;

  logic gnt0;
  logic gnt1;
  logic resp_rd0;
  logic resp_rd1;

  // Round-robin pick; prio only matters when both masters request.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (m0.req && m1.req) begin
      if (prio_q == PRIO_M1) gnt1 = 1'b1;
      else                   gnt0 = 1'b1;
    end else if (m0.req) begin
      gnt0 = 1'b1;
    end else if (m1.req) begin
      gnt1 = 1'b1;
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // RAM port mux; everything is forced to zero when nobody is granted.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (gnt0) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m0.addr;
      ram_we_o    = m0.we;
      ram_be_o    = m0.be;
      ram_wdata_o = m0.wdata;
    end else if (gnt1) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m1.addr;
      ram_we_o    = m1.we;
      ram_be_o    = m1.be;
      ram_wdata_o = m1.wdata;
    end
  end

  // A read response for master x is the cycle where its rv bit and rd_q coincide.
  assign resp_rd0 = rv_q[0] && rd_q;
  assign resp_rd1 = rv_q[1] && rd_q;

  // Next-state for priority, response tracking and read-data hold registers.
  always_comb begin
    prio_d  = prio_q;
    rv_d    = {gnt1, gnt0};
    rd_d    = (gnt0 && !m0.we) || (gnt1 && !m1.we);
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    if (gnt0)      prio_d = PRIO_M1;
    else if (gnt1) prio_d = PRIO_M0;
    if (resp_rd0)  hold0_d = ram_rdata_i;
    if (resp_rd1)  hold1_d = ram_rdata_i;
  end

  // State registers; reset drops any response in flight.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      prio_q  <= PRIO_M0;
      rv_q    <= '0;
      rd_q    <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      prio_q  <= prio_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

  assign m0.rvalid = rv_q[0];
  assign m1.rvalid = rv_q[1];
  assign m0.rdata  = resp_rd0 ? ram_rdata_i : hold0_q;
  assign m1.rdata  = resp_rd1 ? ram_rdata_i : hold1_q;

  // Unused-width guard: BE_WIDTH documents the byte-enable sizing.
  logic [BE_WIDTH-1:0] be_unused;
  assign be_unused = '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: table-driven arbitration vectors, directed
// multi-cycle sequences and constrained-random traffic against a
// memory-level reference model.
module tb_sp_ram_arbiter;
  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int WORDS = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  // RAM wrapper stand-in: one-cycle read latency, junk on the read bus otherwise.
  logic [DW-1:0] ram_mem [WORDS];
  logic          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (ram_en && ram_we) begin
      for (int b = 0; b < BW; b++)
        if (ram_be[b]) ram_mem[ram_addr[AW-1:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (ram_en && !ram_we) ram_rdata <= ram_mem[ram_addr[AW-1:2]];
    else                   ram_rdata <= $urandom;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [WORDS];
  logic          prio_m;
  logic [1:0]    exp_rv;
  logic [DW-1:0] exp_rdata [2];

  // Stimulus state
  logic          req_v   [2];
  logic          we_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [BW-1:0] be_v    [2];
  logic [DW-1:0] wdata_v [2];
  logic          obs_g   [2];
  logic          eg      [2];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic r0;
    logic r1;
    logic g0;
    logic g1;
  } arb_vec_t;
  arb_vec_t tbl [18];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    prio_m       = 1'b0;
    exp_rv       = 2'b00;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic drive();
    m0_if.req = req_v[0]; m0_if.we = we_v[0]; m0_if.addr = addr_v[0];
    m0_if.be = be_v[0];   m0_if.wdata = wdata_v[0];
    m1_if.req = req_v[1]; m1_if.we = we_v[1]; m1_if.addr = addr_v[1];
    m1_if.be = be_v[1];   m1_if.wdata = wdata_v[1];
  endtask

  // One clock: apply inputs after the falling edge, check, then advance the model.
  task automatic cycle();
    int            g;
    logic [AW-1:0] x_addr;
    logic          x_we;
    logic [BW-1:0] x_be;
    logic [DW-1:0] x_wd;
    logic [AW-2-1:0] idx;
    @(negedge clk);
    drive();
    #1;
    eg[0] = req_v[0] && (!req_v[1] || !prio_m);
    eg[1] = req_v[1] && (!req_v[0] ||  prio_m);
    g = eg[1] ? 1 : 0;
    obs_g[0] = m0_if.gnt;
    obs_g[1] = m1_if.gnt;
    x_addr = '0; x_we = 1'b0; x_be = '0; x_wd = '0;
    if (eg[0] || eg[1]) begin
      x_addr = addr_v[g]; x_we = we_v[g]; x_be = be_v[g]; x_wd = wdata_v[g];
    end
    chk("m0_gnt",    32'(m0_if.gnt),    32'(eg[0]));
    chk("m1_gnt",    32'(m1_if.gnt),    32'(eg[1]));
    chk("ram_en",    32'(ram_en),       32'(eg[0] || eg[1]));
    chk("ram_addr",  32'(ram_addr),     32'(x_addr));
    chk("ram_we",    32'(ram_we),       32'(x_we));
    chk("ram_be",    32'(ram_be),       32'(x_be));
    chk("ram_wdata", ram_wdata,         x_wd);
    chk("m0_rvalid", 32'(m0_if.rvalid), 32'(exp_rv[0]));
    chk("m1_rvalid", 32'(m1_if.rvalid), 32'(exp_rv[1]));
    chk("m0_rdata",  m0_if.rdata,       exp_rdata[0]);
    chk("m1_rdata",  m1_if.rdata,       exp_rdata[1]);
    exp_rv = {eg[1], eg[0]};
    if (eg[0] || eg[1]) begin
      idx = addr_v[g][AW-1:2];
      if (we_v[g]) begin
        for (int b = 0; b < BW; b++)
          if (be_v[g][b]) ref_mem[idx][b*8 +: 8] = wdata_v[g][b*8 +: 8];
      end else begin
        exp_rdata[g] = ref_mem[idx];
      end
      prio_m = (g == 0);
    end
  endtask

  task automatic set_m(input int m, input logic rq, input logic we, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    req_v[m] = rq; we_v[m] = we; addr_v[m] = a; be_v[m] = be; wdata_v[m] = d;
  endtask

  task automatic idle_all();
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
  endtask

  // Single access by master m alone; leaves its request dropped for the next cycle.
  task automatic acc(input int m, input logic we, input logic [AW-1:0] a,
                     input logic [BW-1:0] be, input logic [DW-1:0] d);
    idle_all();
    set_m(m, 1'b1, we, a, be, d);
    cycle();
    req_v[m] = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    drive();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    for (int m = 0; m < 2; m++) set_m(m, 1'b0, 1'b0, '0, '0, '0);
    model_reset();
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0};

    drive();
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("reset_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("reset_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    chk("reset_m0_rdata",  m0_if.rdata, 32'd0);
    chk("reset_m1_rdata",  m1_if.rdata, 32'd0);

    // Contention / round-robin table, addresses advance only after a grant.
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 18; i++) begin
      set_m(0, tbl[i].r0, 1'b0, AW'(32'h200 + 32'(cnt0 * 4)), 4'hF, 32'h0);
      set_m(1, tbl[i].r1, 1'b0, AW'(32'h300 + 32'(cnt1 * 4)), 4'hF, 32'h0);
      cycle();
      chk("tbl_gnt0", 32'(obs_g[0]), 32'(tbl[i].g0));
      chk("tbl_gnt1", 32'(obs_g[1]), 32'(tbl[i].g1));
      if (tbl[i].g0) cnt0++;
      if (tbl[i].g1) cnt1++;
    end
    idle_all();
    cycle();

    // Reset between a read grant and its response.
    acc(0, 1'b0, 15'h0040, 4'hF, 32'h0);
    cycle();
    acc(0, 1'b0, 15'h0044, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    drive();
    #1;
    chk("midrd_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("midrd_m0_rdata",  m0_if.rdata, 32'd0);
    chk("midrd_m1_rdata",  m1_if.rdata, 32'd0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) cycle();
    chk("post_rst_rvalid", 32'(m0_if.rvalid), 32'd0);
    set_m(0, 1'b1, 1'b0, 15'h0048, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 15'h004C, 4'hF, 32'h0);
    cycle();
    chk("post_rst_prio", 32'(obs_g[0]), 32'd1);
    req_v[0] = 1'b0;
    cycle();
    idle_all();
    cycle();

    // Single write then read by m1, held across idle cycles.
    acc(1, 1'b1, 15'h0100, 4'hF, 32'hDEAD_BEEF);
    cycle();
    chk("m1_wr_rvalid", 32'(m1_if.rvalid), 32'd1);
    acc(1, 1'b0, 15'h0100, 4'hF, 32'h0);
    cycle();
    chk("m1_rd_rvalid", 32'(m1_if.rvalid), 32'd1);
    chk("m1_rd_data",   m1_if.rdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("m1_rd_hold", m1_if.rdata, 32'hDEAD_BEEF);
    end

    // Byte-enable write.
    acc(1, 1'b1, 15'h0100, 4'h1, 32'h0000_00AA);
    acc(1, 1'b0, 15'h0100, 4'hF, 32'h0);
    cycle();
    chk("be_rd_data", m1_if.rdata, 32'hDEAD_BEAA);

    // Back-to-back m0 writes then reads.
    idle_all();
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1'b1, 1'b1, AW'(k * 4), 4'hF, 32'(k + 1));
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      set_m(0, k < 4, 1'b0, AW'(k * 4), 4'hF, 32'h0);
      cycle();
      if (k > 0) begin
        chk("b2b_rvalid", 32'(m0_if.rvalid), 32'd1);
        chk("b2b_rdata",  m0_if.rdata, 32'(k));
        chk("b2b_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
      end
    end

    // Write response leaves held read data alone.
    acc(0, 1'b1, 15'h0080, 4'hF, 32'h1234_5678);
    acc(0, 1'b0, 15'h0080, 4'hF, 32'h0);
    acc(0, 1'b1, 15'h0084, 4'hF, 32'h0000_CAFE);
    cycle();
    chk("wr_resp_rvalid", 32'(m0_if.rvalid), 32'd1);
    chk("wr_resp_hold",   m0_if.rdata, 32'h1234_5678);

    // Random traffic; a pending request keeps its payload until granted.
    idle_all();
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req_v[m]) begin
          set_m(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                AW'({$urandom_range(0, 15), 2'($urandom_range(0, 3))}),
                BW'($urandom), $urandom);
        end
      end
      cycle();
      for (int m = 0; m < 2; m++) if (eg[m]) req_v[m] = 1'b0;
    end
    idle_all();
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
